// File: rtl/dizy_ctrl_pkg.sv
// Shared definitions for the DIZY keystream controller.
// - ctrl_state_e : sequencer states
// - DEF_*        : default widths for the core interface
// - CORE_UPD_CYC : cycles from a core strobe until its state is valid
package dizy_ctrl_pkg;

    localparam int DEF_SIZE_STATE = 128;
    localparam int DEF_SIZE_KEY   = 128;

    localparam int DEF_SIZE_KS  = 64;
    localparam int CORE_UPD_CYC = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_WAIT_KEY,
        ST_IV,
        ST_WAIT_IV,
        ST_GEN,
        ST_WAIT_GEN,
        ST_DRAIN
    } ctrl_state_e;

endpackage

// File: rtl/ks_fifo2.sv
// Two-entry registered FIFO for keystream words.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (accepted when not full, or full with a pop)
//   pop_i        : consumer ready; a pop happens only when the FIFO holds data
//   head_o       : oldest word
//   valid_o      : FIFO not empty
//   full_o       : both slots occupied
module ks_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic         full_o
);

    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push;
    logic       do_pop;
    logic [1:0] slot_wen;

    always_comb begin
        do_pop  = pop_i && (cnt_q != 2'd0);
        // When full, a simultaneous pop frees the slot the write lands in.
        do_push = push_i && ((cnt_q != 2'd2) || do_pop);
        wr_d    = do_push ? ~wr_q : wr_q;
        rd_d    = do_pop ? ~rd_q : rd_q;
        cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [W-1:0] slot_q, slot_d;

            assign slot_wen[gi] = do_push && (wr_q == gi[0]);

            always_comb begin
                slot_d = slot_wen[gi] ? push_data_i : slot_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) slot_q <= '0;
                else     slot_q <= slot_d;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = rd_q ? g_slot[1].slot_q : g_slot[0].slot_q;
    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/dizy_ks_ctrl.sv
// Sequencer and keystream buffer in front of the one-round-per-cycle DIZY core.
// Absorbs the key (load), the IV (next), then issues one keystream update per
// word and buffers the low SIZE_KS bits of the resulting core state.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, key, iv, num_words: session request, captured in IDLE when core idle
//   busy, done               : session in progress / one-cycle end pulse
//   ks_data, ks_valid, ks_ready : keystream output handshake
//   core_load, core_next, core_key : core strobes and key/IV input
//   core_busy, core_state    : core status and state
module dizy_ks_ctrl
    import dizy_ctrl_pkg::*;
#(
    parameter int SIZE_STATE = DEF_SIZE_STATE,
    parameter int SIZE_KEY   = DEF_SIZE_KEY,
    parameter int SIZE_KS    = DEF_SIZE_KS,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_KEY-1:0]   key,
    input  logic [SIZE_KEY-1:0]   iv,
    input  logic [CNT_W-1:0]      num_words,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE_KS-1:0]    ks_data,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  core_load,
    output logic                  core_next,
    output logic [SIZE_KEY-1:0]   core_key,
    input  logic                  core_busy,
    input  logic [SIZE_STATE-1:0] core_state
);

    ctrl_state_e         state_q, state_d;
    logic [SIZE_KEY-1:0] key_q, key_d;
    logic [SIZE_KEY-1:0] iv_q, iv_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                push;
    logic                fifo_full;
    logic                unused_core_state;

    // Only the low SIZE_KS bits are buffered; the reduction keeps the rest tied off.
    assign unused_core_state = ^core_state;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        iv_d    = iv_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The core has no reset, so a session abandoned by rst may
                // still be running an update; never strobe over it.
                if (start && !core_busy) begin
                    key_d   = key;
                    iv_d    = iv;
                    cnt_d   = num_words;
                    state_d = ST_KEY;
                end
            end
            ST_KEY:      state_d = ST_WAIT_KEY;
            ST_WAIT_KEY: if (!core_busy) state_d = ST_IV;
            ST_IV:       state_d = ST_WAIT_IV;
            ST_WAIT_IV: begin
                if (!core_busy) state_d = (cnt_q != '0) ? ST_GEN : ST_DRAIN;
            end
            ST_GEN: begin
                // Hold off the update until its result is sure to find a slot.
                if (!fifo_full) state_d = ST_WAIT_GEN;
            end
            ST_WAIT_GEN: begin
                if (!core_busy) begin
                    push    = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q != CNT_W'(1)) ? ST_GEN : ST_DRAIN;
                end
            end
            ST_DRAIN:    if (!ks_valid) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            iv_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes and core_key depend only on registered state.
    always_comb begin
        core_load = (state_q == ST_KEY);
        core_next = (state_q == ST_IV) || ((state_q == ST_GEN) && !fifo_full);
        case (state_q)
            ST_KEY, ST_WAIT_KEY: core_key = key_q;
            ST_IV, ST_WAIT_IV:   core_key = iv_q;
            default:             core_key = '0;
        endcase
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DRAIN) && !ks_valid;
    end

    ks_fifo2 #(
        .W (SIZE_KS)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (core_state[SIZE_KS-1:0]),
        .pop_i       (ks_ready),
        .head_o      (ks_data),
        .valid_o     (ks_valid),
        .full_o      (fifo_full)
    );

endmodule
